// File: rtl/cpu4_pkg.sv
// Shared constants and types for the CPU4 program loader slice.
//   DEFAULT_DEPTH / DEFAULT_WIDTH : default program memory geometry
//   state_t                       : loader FSM state encoding (two bits)
package cpu4_pkg;

    localparam int unsigned DEFAULT_DEPTH = 16;
    localparam int unsigned DEFAULT_WIDTH = 8;

    // IDLE is all-zero so the state register clears to it on reset.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

endpackage : cpu4_pkg

// File: rtl/prog_loader_if.sv
// Host load channel and CPU fetch channel of the program loader.
//   master : host/CPU side (drives load_req, wr_data, wr_valid, fetch_addr)
//   slave  : loader side   (drives wr_ready, fetch_data, cpu_run, checksum, load_err)
interface prog_loader_if
    import cpu4_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic             load_req;
    logic [WIDTH-1:0] wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [AW-1:0]    fetch_addr;
    logic [WIDTH-1:0] fetch_data;
    logic             cpu_run;
    logic [WIDTH-1:0] checksum;
    logic             load_err;

    modport master (
        output load_req,
        output wr_data,
        output wr_valid,
        output fetch_addr,
        input  wr_ready,
        input  fetch_data,
        input  cpu_run,
        input  checksum,
        input  load_err
    );

    modport slave (
        input  load_req,
        input  wr_data,
        input  wr_valid,
        input  fetch_addr,
        output wr_ready,
        output fetch_data,
        output cpu_run,
        output checksum,
        output load_err
    );

endinterface : prog_loader_if

// File: rtl/prog_mem.sv
// Program storage: DEPTH x WIDTH array, one synchronous write port and
// one registered read port.
//   CLK, RESET_B : clock, async active-low reset (read register only)
//   wr_en        : write wr_data at wr_addr on the rising edge
//   rd_addr      : read address, sampled on the rising edge
//   rd_data      : registered read data (old word on a same-address write)
module prog_mem
    import cpu4_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET_B,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array write; contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register; sampling before the write lands gives read-old-data.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : prog_mem

// File: rtl/prog_loader.sv
// Program loader: accepts a full program image from a host into prog_mem,
// then enables the CPU, which fetches instructions through a registered port.
//   CLK, RESET_B : clock, async active-low reset
//   bus (slave)  : load_req/wr_data/wr_valid/wr_ready host channel,
//                  fetch_addr/fetch_data CPU channel,
//                  cpu_run, checksum, load_err status
module prog_loader
    import cpu4_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic          CLK,
    input  logic          RESET_B,
    prog_loader_if.slave  bus
);

    localparam int unsigned   AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] checksum_q;
    logic             load_err_q;
    logic             cpu_run_q;
    logic [WIDTH-1:0] rd_data;

    logic             wr_ready_c;
    logic             accept_c;
    logic             enter_load_c;
    logic             abort_c;

    // Handshake: ready only while loading and the host still requests it.
    assign wr_ready_c = (state_q == ST_LOAD) && bus.load_req;
    assign accept_c   = wr_ready_c && bus.wr_valid;

    // State register.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d      = state_q;
        enter_load_c = 1'b0;
        abort_c      = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (bus.load_req) begin
                    state_d      = ST_LOAD;
                    enter_load_c = 1'b1;
                end
            end
            ST_LOAD: begin
                // Still in LOAD means the image is incomplete, so a drop is an error.
                if (!bus.load_req) begin
                    state_d = ST_IDLE;
                    abort_c = 1'b1;
                end else if (accept_c && (addr_q == LAST_ADDR)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write address, running checksum, sticky error and run enable.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            addr_q     <= '0;
            checksum_q <= '0;
            load_err_q <= 1'b0;
            cpu_run_q  <= 1'b0;
        end else begin
            cpu_run_q <= (state_q == ST_RUN);
            if (enter_load_c) begin
                addr_q     <= '0;
                checksum_q <= '0;
                load_err_q <= 1'b0;
            end else begin
                if (accept_c) begin
                    addr_q     <= addr_q + AW'(1);
                    checksum_q <= checksum_q ^ bus.wr_data;
                end
                if (abort_c) begin
                    load_err_q <= 1'b1;
                end
            end
        end
    end

    prog_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_prog_mem (
        .CLK     (CLK),
        .RESET_B (RESET_B),
        .wr_en   (accept_c),
        .wr_addr (addr_q),
        .wr_data (bus.wr_data),
        .rd_addr (bus.fetch_addr),
        .rd_data (rd_data)
    );

    assign bus.wr_ready   = wr_ready_c;
    assign bus.fetch_data = rd_data;
    assign bus.cpu_run    = cpu_run_q;
    assign bus.checksum   = checksum_q;
    assign bus.load_err   = load_err_q;

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

    logic clk;
    logic reset_b;
    int   n_assert;
    int   n_fail;
    int   acc;

    prog_loader_if #(.DEPTH(16), .WIDTH(8)) bus ();

    prog_loader #(
        .DEPTH (16),
        .WIDTH (8)
    ) dut (
        .CLK     (clk),
        .RESET_B (reset_b),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] word_of(input int mode, input logic [7:0] base, input int i);
        logic [7:0] w;
        case (mode)
            0:       w = base + 8'(i);
            1:       w = base;
            2:       w = base - 8'(i);
            default: w = 8'(8'h11 * (i + 1));
        endcase
        return w;
    endfunction

    // Offers words until n are accepted (bounded); called and returning at a negedge.
    task automatic load_words(input int n, input int mode, input logic [7:0] base,
                              input bit toggle, input bit drop, output int accepted);
        int   cyc;
        logic rdy;
        accepted = 0;
        cyc      = 0;
        while (accepted < n && cyc < 200) begin
            bus.wr_data  = word_of(mode, base, accepted);
            bus.wr_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            rdy          = bus.wr_ready;
            @(negedge clk);
            cyc++;
            if (bus.wr_valid && rdy) accepted++;
        end
        bus.wr_valid = 1'b0;
        if (drop) bus.load_req = 1'b0;
    endtask

    task automatic fetch_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        bus.fetch_addr = a;
        @(negedge clk);
        chk(tag, 32'(bus.fetch_data), 32'(exp));
    endtask

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        reset_b        = 1'b0;
        bus.load_req   = 1'b0;
        bus.wr_data    = '0;
        bus.wr_valid   = 1'b0;
        bus.fetch_addr = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_fetch_data", 32'(bus.fetch_data), 32'h0);
        chk("rst_cpu_run",    32'(bus.cpu_run),    32'h0);
        chk("rst_checksum",   32'(bus.checksum),   32'h0);
        chk("rst_load_err",   32'(bus.load_err),   32'h0);
        reset_b = 1'b1;
        @(negedge clk);
        chk("idle_wr_ready",  32'(bus.wr_ready),   32'h0);

        // Full load 0x00..0x0F, valid held high
        bus.load_req = 1'b1;
        @(negedge clk);
        chk("l1_wr_ready", 32'(bus.wr_ready), 32'h1);
        load_words(16, 0, 8'h00, 1'b0, 1'b1, acc);
        chk("l1_accepts",      32'(acc),            32'd16);
        chk("l1_run_lag",      32'(bus.cpu_run),    32'h0);
        chk("l1_wr_ready_off", 32'(bus.wr_ready),   32'h0);
        chk("l1_checksum",     32'(bus.checksum),   32'h00);
        chk("l1_load_err",     32'(bus.load_err),   32'h0);
        @(negedge clk);
        chk("l1_cpu_run",      32'(bus.cpu_run),    32'h1);
        fetch_chk("l1_fetch0",  4'd0,  8'h00);
        fetch_chk("l1_fetch5",  4'd5,  8'h05);
        fetch_chk("l1_fetch15", 4'd15, 8'h0F);

        // Same-address write and fetch returns old word first
        bus.load_req = 1'b1;
        @(negedge clk);
        chk("rw_wr_ready", 32'(bus.wr_ready), 32'h1);
        load_words(3, 0, 8'h00, 1'b0, 1'b0, acc);
        bus.fetch_addr = 4'd3;
        bus.wr_data    = 8'h3C;
        bus.wr_valid   = 1'b1;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        chk("rw_old_word", 32'(bus.fetch_data), 32'h03);
        @(negedge clk);
        chk("rw_new_word", 32'(bus.fetch_data), 32'h3C);
        bus.load_req = 1'b0;
        @(negedge clk);
        chk("rw_abort_err",  32'(bus.load_err), 32'h1);
        chk("rw_abort_csum", 32'(bus.checksum), 32'h3F);

        // 0xA5 everywhere, valid toggling
        bus.load_req = 1'b1;
        @(negedge clk);
        chk("a5_err_clear",  32'(bus.load_err), 32'h0);
        chk("a5_csum_clear", 32'(bus.checksum), 32'h0);
        load_words(16, 1, 8'hA5, 1'b1, 1'b1, acc);
        chk("a5_accepts",    32'(acc),          32'd16);
        chk("a5_wr_ready",   32'(bus.wr_ready), 32'h0);
        chk("a5_checksum",   32'(bus.checksum), 32'h00);
        @(negedge clk);
        chk("a5_cpu_run",    32'(bus.cpu_run),  32'h1);
        fetch_chk("a5_fetch7", 4'd7, 8'hA5);
        fetch_chk("a5_fetch3", 4'd3, 8'hA5);

        // Reload from RUN with 0xFF..0xF0
        bus.load_req = 1'b1;
        @(negedge clk);
        chk("rl_wr_ready",  32'(bus.wr_ready), 32'h1);
        @(negedge clk);
        chk("rl_cpu_fall",  32'(bus.cpu_run),  32'h0);
        load_words(16, 2, 8'hFF, 1'b0, 1'b1, acc);
        chk("rl_accepts",   32'(acc),          32'd16);
        chk("rl_checksum",  32'(bus.checksum), 32'h00);
        @(negedge clk);
        chk("rl_cpu_run",   32'(bus.cpu_run),  32'h1);
        fetch_chk("rl_fetch0",  4'd0,  8'hFF);
        fetch_chk("rl_fetch15", 4'd15, 8'hF0);

        // Abort after 5 accepts, then restart at address 0
        bus.load_req = 1'b1;
        @(negedge clk);
        load_words(5, 3, 8'h00, 1'b0, 1'b0, acc);
        chk("ab_checksum",  32'(bus.checksum), 32'h11);
        bus.load_req = 1'b0;
        @(negedge clk);
        chk("ab_load_err",  32'(bus.load_err), 32'h1);
        chk("ab_cpu_run",   32'(bus.cpu_run),  32'h0);
        chk("ab_wr_ready",  32'(bus.wr_ready), 32'h0);
        bus.load_req = 1'b1;
        @(negedge clk);
        chk("ab_err_clear", 32'(bus.load_err), 32'h0);
        chk("ab_csum_clr",  32'(bus.checksum), 32'h0);
        chk("ab_ready_on",  32'(bus.wr_ready), 32'h1);
        load_words(1, 1, 8'h99, 1'b0, 1'b1, acc);
        @(negedge clk);
        fetch_chk("ab_fetch0", 4'd0, 8'h99);
        fetch_chk("ab_fetch1", 4'd1, 8'h22);
        fetch_chk("ab_fetch5", 4'd5, 8'hFA);

        // Async reset during word 9, then a clean full load
        bus.load_req = 1'b1;
        @(negedge clk);
        load_words(8, 0, 8'h41, 1'b0, 1'b0, acc);
        chk("rs_pre_csum",  32'(bus.checksum),   32'h08);
        chk("rs_pre_fetch", 32'(bus.fetch_data), 32'h46);
        bus.wr_data  = 8'h49;
        bus.wr_valid = 1'b1;
        #2;
        reset_b = 1'b0;
        #1;
        chk("rs_fetch_data", 32'(bus.fetch_data), 32'h0);
        chk("rs_cpu_run",    32'(bus.cpu_run),    32'h0);
        chk("rs_checksum",   32'(bus.checksum),   32'h0);
        chk("rs_load_err",   32'(bus.load_err),   32'h0);
        chk("rs_wr_ready",   32'(bus.wr_ready),   32'h0);
        @(negedge clk);
        reset_b      = 1'b1;
        bus.wr_valid = 1'b0;
        bus.load_req = 1'b0;
        @(negedge clk);
        bus.load_req = 1'b1;
        @(negedge clk);
        load_words(16, 0, 8'h50, 1'b0, 1'b1, acc);
        chk("rs_accepts",  32'(acc),          32'd16);
        chk("rs_checksum_full", 32'(bus.checksum), 32'h00);
        @(negedge clk);
        chk("rs_cpu_run_full",  32'(bus.cpu_run),  32'h1);
        fetch_chk("rs_fetch0", 4'd0, 8'h50);
        fetch_chk("rs_fetch9", 4'd9, 8'h59);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule : tb_prog_loader
